multicycle_main_control: RTL and testbench

- Main control FSM for the multi-cycle RISC-V core.
- Sits directly upstream of alu_control: it decodes the instruction opcode and sequences fetch/decode/execute/memory/writeback.
- Drives the 2-bit alu_op consumed by alu_control, plus all datapath mux, register-file, PC and memory enables.
- Memory accesses use a simple ready handshake.

---
 rtl/multicycle_main_control.sv | 206 ++++++++++++++++++++
 tb/tb_multicycle_main_control.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle RISC-V core: sequences fetch/decode/execute/memory/writeback.
// Optional build macro ILLEGAL_TRAP_EN: unknown opcodes trap (sticky illegal_instr_o) instead of NOP.
module multicycle_main_control #(
  parameter int unsigned WAIT_LIMIT = 0,
  parameter int unsigned STATE_W    = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [6:0]         opcode_i,
  input  logic               mem_ready_i,
  input  logic               zero_i,
  output logic               pc_write_o,
  output logic               pc_write_cond_o,
  output logic               pc_src_o,
  output logic               i_or_d_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               ir_write_o,
  output logic               reg_write_o,
  output logic [1:0]         mem_to_reg_o,
  output logic [1:0]         alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic [1:0]         alu_op_o,
  output logic               mem_timeout_o,
  output logic               illegal_instr_o,
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecR   = 4'd6,
    StExecI   = 4'd7,
    StAluWb   = 4'd8,
    StBranch  = 4'd9,
    StJal     = 4'd10,
    StTrap    = 4'd11
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  state_e state_q, state_d;
  logic   timeout;
  logic   illegal_q;

  // The zero flag is consumed by the datapath PC enable, not by this FSM.
  logic unused_zero;
  assign unused_zero = zero_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: begin
        if (mem_ready_i)  state_d = StDecode;
        else if (timeout) state_d = StFetch;
      end
      StDecode: begin
        case (opcode_i)
          OpLoad, OpStore: state_d = StMemAddr;
          OpRType:         state_d = StExecR;
          OpIType:         state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
`ifdef ILLEGAL_TRAP_EN
          default:         state_d = StTrap;
`else
          default:         state_d = StFetch;
`endif
        endcase
      end
      StMemAddr: state_d = (opcode_i == OpStore) ? StMemWr : StMemRd;
      StMemRd: begin
        if (mem_ready_i)  state_d = StMemWb;
        else if (timeout) state_d = StFetch;
      end
      StMemWr: begin
        if (mem_ready_i || timeout) state_d = StFetch;
      end
      StExecR, StExecI: state_d = StAluWb;
      StMemWb, StAluWb, StBranch, StJal: state_d = StFetch;
`ifdef ILLEGAL_TRAP_EN
      StTrap: state_d = StTrap;
`endif
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= illegal_q | (state_d == StTrap);
`else
      illegal_q <= 1'b0;
`endif
    end
  end

  // Wait counter only exists when a finite limit is configured.
  if (WAIT_LIMIT > 0) begin : g_wait
    localparam int unsigned CntW = $clog2(WAIT_LIMIT + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            waiting;

    assign waiting = (state_q inside {StFetch, StMemRd, StMemWr}) && !mem_ready_i;
    assign timeout = waiting && (cnt_q == CntW'(WAIT_LIMIT - 1));

    always_comb begin
      cnt_d = cnt_q;
      if (timeout || (state_d != state_q)) cnt_d = '0;
      else if (waiting)                    cnt_d = cnt_q + CntW'(1);
    end

    always_ff @(posedge clk_i) begin
      if (reset_i) cnt_q <= '0;
      else         cnt_q <= cnt_d;
    end
  end else begin : g_no_wait
    assign timeout = 1'b0;
  end

  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    pc_src_o        = 1'b0;
    i_or_d_o        = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    reg_write_o     = 1'b0;
    mem_to_reg_o    = 2'b00;
    alu_src_a_o     = 2'b00;
    alu_src_b_o     = 2'b00;
    alu_op_o        = 2'b00;
    mem_timeout_o   = 1'b0;
    illegal_instr_o = 1'b0;
    if (!reset_i) begin
      mem_timeout_o   = timeout;
      illegal_instr_o = illegal_q;
      case (state_q)
        StFetch: begin
          mem_read_o  = 1'b1;
          alu_src_b_o = 2'b01;
          ir_write_o  = mem_ready_i;
          pc_write_o  = mem_ready_i;
        end
        StDecode: alu_src_b_o = 2'b10;
        StMemAddr: begin
          alu_src_a_o = 2'b01;
          alu_src_b_o = 2'b10;
        end
        StMemRd: begin
          mem_read_o = 1'b1;
          i_or_d_o   = 1'b1;
        end
        StMemWb: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = 2'b01;
        end
        StMemWr: begin
          mem_write_o = 1'b1;
          i_or_d_o    = 1'b1;
        end
        StExecR: begin
          alu_src_a_o = 2'b01;
          alu_op_o    = 2'b10;
        end
        StExecI: begin
          alu_src_a_o = 2'b01;
          alu_src_b_o = 2'b10;
          alu_op_o    = 2'b10;
        end
        StAluWb: reg_write_o = 1'b1;
        StBranch: begin
          alu_src_a_o     = 2'b01;
          alu_op_o        = 2'b01;
          pc_write_cond_o = 1'b1;
          pc_src_o        = 1'b1;
        end
        StJal: begin
          // PC already advanced in fetch, so the link value written here is PC+4.
          pc_write_o   = 1'b1;
          pc_src_o     = 1'b1;
          reg_write_o  = 1'b1;
          mem_to_reg_o = 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign state_o = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control: an untimed instance (WAIT_LIMIT=0) and a limit-4 one.
module tb_multicycle_main_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic       rdy;
  logic       zero = 1'b0;

  logic       a_pw, a_pwc, a_psrc, a_iord, a_mrd, a_mwr, a_irw, a_rw, a_to, a_ill;
  logic [1:0] a_m2r, a_asa, a_asb, a_aop;
  logic [3:0] a_st;
  logic       b_pw, b_pwc, b_psrc, b_iord, b_mrd, b_mwr, b_irw, b_rw, b_to, b_ill;
  logic [1:0] b_m2r, b_asa, b_asb, b_aop;
  logic [3:0] b_st;
  logic [17:0] a_ctl, b_ctl;

  assign a_ctl = {a_pw, a_pwc, a_psrc, a_iord, a_mrd, a_mwr, a_irw, a_rw,
                  a_m2r, a_asa, a_asb, a_aop, a_to, a_ill};
  assign b_ctl = {b_pw, b_pwc, b_psrc, b_iord, b_mrd, b_mwr, b_irw, b_rw,
                  b_m2r, b_asa, b_asb, b_aop, b_to, b_ill};

  always #5 clk = ~clk;

  multicycle_main_control #(.WAIT_LIMIT(0), .STATE_W(4)) u_dut_a (
    .clk_i(clk), .reset_i(rst), .opcode_i(op), .mem_ready_i(rdy), .zero_i(zero),
    .pc_write_o(a_pw), .pc_write_cond_o(a_pwc), .pc_src_o(a_psrc), .i_or_d_o(a_iord),
    .mem_read_o(a_mrd), .mem_write_o(a_mwr), .ir_write_o(a_irw), .reg_write_o(a_rw),
    .mem_to_reg_o(a_m2r), .alu_src_a_o(a_asa), .alu_src_b_o(a_asb), .alu_op_o(a_aop),
    .mem_timeout_o(a_to), .illegal_instr_o(a_ill), .state_o(a_st)
  );

  multicycle_main_control #(.WAIT_LIMIT(4), .STATE_W(4)) u_dut_b (
    .clk_i(clk), .reset_i(rst), .opcode_i(op), .mem_ready_i(rdy), .zero_i(zero),
    .pc_write_o(b_pw), .pc_write_cond_o(b_pwc), .pc_src_o(b_psrc), .i_or_d_o(b_iord),
    .mem_read_o(b_mrd), .mem_write_o(b_mwr), .ir_write_o(b_irw), .reg_write_o(b_rw),
    .mem_to_reg_o(b_m2r), .alu_src_a_o(b_asa), .alu_src_b_o(b_asb), .alu_op_o(b_aop),
    .mem_timeout_o(b_to), .illegal_instr_o(b_ill), .state_o(b_st)
  );

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] JL = 7'b1101111;
  localparam logic [6:0] BD = 7'b1111111;

  typedef struct {
    logic        r;
    logic [6:0]  o;
    logic        y;
    logic [3:0]  st;
    logic        chk;
    logic [17:0] ctl;
  } vec_t;

  vec_t  vecs[$];
  string names[$];
  int    n_vec = 0;
  int    n_bad = 0;

  logic [17:0] z, f1, f0, dec, ma, mrd, mwb, mwr, exr, exi, awb, br, jal, trp, f0_to, mwr_to;

  function automatic logic [17:0] mk(input logic pw, pwc, psrc, iord, mrd_, mwr_, irw, rw,
                                     input logic [1:0] m2r, asa, asb, aop,
                                     input logic to, ill);
    return {pw, pwc, psrc, iord, mrd_, mwr_, irw, rw, m2r, asa, asb, aop, to, ill};
  endfunction

  task automatic add(input string nm, input logic r, input logic [6:0] o, input logic y,
                     input logic [3:0] s, input logic c, input logic [17:0] e);
    vec_t v;
    v.r = r; v.o = o; v.y = y; v.st = s; v.chk = c; v.ctl = e;
    vecs.push_back(v);
    names.push_back(nm);
  endtask

  task automatic cmp(input string nm, input logic [3:0] st_act, input logic [17:0] ctl_act,
                     input logic [3:0] st_exp, input logic chk, input logic [17:0] ctl_exp);
    n_vec++;
    if ((ctl_act !== ctl_exp) || (chk && (st_act !== st_exp))) begin
      n_bad++;
      $display("FAIL %s: got state=%0d ctl=%b, expected state=%0d ctl=%b",
               nm, st_act, ctl_act, st_exp, ctl_exp);
    end
  endtask

  task automatic drive(input logic r, input logic [6:0] o, input logic y);
    rst = r; op = o; rdy = y;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; op = R; rdy = 1'b1;
    //        pw    pwc   psrc  iord  mrd   mwr   irw   rw    m2r   asa   asb   aop   to    ill
    z     = '0;
    f1    = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0);
    f0    = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0);
    f0_to = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b1, 1'b0);
    dec   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0);
    ma    = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 2'd0, 1'b0, 1'b0);
    mrd   = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    mwb   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    mwr   = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    mwr_to= mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
    exr   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0, 2'd2, 1'b0, 1'b0);
    exi   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 2'd2, 1'b0, 1'b0);
    awb   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    br    = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0, 2'd1, 1'b0, 1'b0);
    jal   = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    trp   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1);

    //  name          rst   op  rdy   state chk   ctl
    add("rst0",       1'b1, R,  1'b1, 4'd0,  1'b0, z);
    add("rst1",       1'b1, R,  1'b1, 4'd0,  1'b1, z);
    add("r_fetch",    1'b0, R,  1'b1, 4'd0,  1'b1, f1);
    add("r_dec",      1'b0, R,  1'b1, 4'd1,  1'b1, dec);
    add("r_exec",     1'b0, BD, 1'b1, 4'd6,  1'b1, exr);
    add("r_wb",       1'b0, BD, 1'b1, 4'd8,  1'b1, awb);
    add("i_fetch",    1'b0, BD, 1'b1, 4'd0,  1'b1, f1);
    add("i_dec",      1'b0, I,  1'b1, 4'd1,  1'b1, dec);
    add("i_exec",     1'b0, BD, 1'b0, 4'd7,  1'b1, exi);
    add("i_wb",       1'b0, BD, 1'b0, 4'd8,  1'b1, awb);
    add("ld_fetch",   1'b0, BD, 1'b1, 4'd0,  1'b1, f1);
    add("ld_dec",     1'b0, LD, 1'b1, 4'd1,  1'b1, dec);
    add("ld_addr",    1'b0, LD, 1'b1, 4'd2,  1'b1, ma);
    add("ld_wait0",   1'b0, LD, 1'b0, 4'd3,  1'b1, mrd);
    add("ld_wait1",   1'b0, ST, 1'b0, 4'd3,  1'b1, mrd);
    add("ld_wait2",   1'b0, R,  1'b0, 4'd3,  1'b1, mrd);
    add("ld_ready",   1'b0, R,  1'b1, 4'd3,  1'b1, mrd);
    add("ld_wb",      1'b0, R,  1'b1, 4'd4,  1'b1, mwb);
    add("f_stall0",   1'b0, BD, 1'b0, 4'd0,  1'b1, f0);
    add("f_stall1",   1'b0, BD, 1'b0, 4'd0,  1'b1, f0);
    add("br_fetch",   1'b0, BD, 1'b1, 4'd0,  1'b1, f1);
    add("br_dec",     1'b0, BR, 1'b1, 4'd1,  1'b1, dec);
    add("br_exec",    1'b0, BD, 1'b1, 4'd9,  1'b1, br);
    add("jal_fetch",  1'b0, BD, 1'b1, 4'd0,  1'b1, f1);
    add("jal_dec",    1'b0, JL, 1'b1, 4'd1,  1'b1, dec);
    add("jal",        1'b0, BD, 1'b1, 4'd10, 1'b1, jal);
    add("st_fetch",   1'b0, BD, 1'b1, 4'd0,  1'b1, f1);
    add("st_dec",     1'b0, ST, 1'b1, 4'd1,  1'b1, dec);
    add("st_addr",    1'b0, ST, 1'b0, 4'd2,  1'b1, ma);
    add("st_wait",    1'b0, LD, 1'b0, 4'd5,  1'b1, mwr);
    add("st_ready",   1'b0, LD, 1'b1, 4'd5,  1'b1, mwr);
    add("bad_fetch",  1'b0, BD, 1'b1, 4'd0,  1'b1, f1);
    add("bad_dec",    1'b0, BD, 1'b1, 4'd1,  1'b1, dec);
`ifdef ILLEGAL_TRAP_EN
    add("trap0",      1'b0, BD, 1'b1, 4'd11, 1'b1, trp);
    add("trap1",      1'b0, R,  1'b1, 4'd11, 1'b1, trp);
    add("trap_rst",   1'b1, R,  1'b1, 4'd11, 1'b1, z);
    add("trap_clr",   1'b0, R,  1'b0, 4'd0,  1'b1, f0);
`else
    add("bad_nop",    1'b0, BD, 1'b0, 4'd0,  1'b1, f0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].r, vecs[i].o, vecs[i].y);
      cmp({names[i], "_a"}, a_st, a_ctl, vecs[i].st, vecs[i].chk, vecs[i].ctl);
      cmp({names[i], "_b"}, b_st, b_ctl, vecs[i].st, vecs[i].chk, vecs[i].ctl);
      tick();
    end

    // Reset while a load waits in MEM_RD: access abandoned, counter restarts from zero.
    drive(1'b1, R, 1'b0); tick();
    drive(1'b0, BD, 1'b1); tick();
    drive(1'b0, LD, 1'b1); tick();
    drive(1'b0, LD, 1'b1); tick();
    drive(1'b0, LD, 1'b0); tick();
    drive(1'b0, LD, 1'b0); tick();
    drive(1'b1, LD, 1'b1);
    cmp("rst_in_rd_a", a_st, a_ctl, 4'd3, 1'b1, z);
    cmp("rst_in_rd_b", b_st, b_ctl, 4'd3, 1'b1, z);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, LD, 1'b0);
      cmp($sformatf("post_rst_fetch%0d_a", k), a_st, a_ctl, 4'd0, 1'b1, f0);
      cmp($sformatf("post_rst_fetch%0d_b", k), b_st, b_ctl, 4'd0, 1'b1, (k == 3) ? f0_to : f0);
      tick();
    end
    drive(1'b0, LD, 1'b0);
    cmp("fetch_after_to_b", b_st, b_ctl, 4'd0, 1'b1, f0);
    tick();

    // Store that never completes: limit-4 instance times out, untimed one waits on.
    drive(1'b0, BD, 1'b1); tick();
    drive(1'b0, ST, 1'b1); tick();
    drive(1'b0, ST, 1'b0); tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, R, 1'b0);
      cmp($sformatf("st_hang%0d_a", k), a_st, a_ctl, 4'd5, 1'b1, mwr);
      cmp($sformatf("st_hang%0d_b", k), b_st, b_ctl, 4'd5, 1'b1, (k == 3) ? mwr_to : mwr);
      tick();
    end
    drive(1'b0, R, 1'b0);
    cmp("st_after_to_b", b_st, b_ctl, 4'd0, 1'b1, f0);
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, R, 1'b0);
      cmp($sformatf("st_forever%0d_a", k), a_st, a_ctl, 4'd5, 1'b1, mwr);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
